// File: rtl/race_distance_tracker.sv
// Race distance integrator and run timer with a three-state race FSM (IDLE/RUNNING/FINISHED).
// Optional split-time capture at half distance is enabled by defining SPLIT_TIME_EN.
module race_distance_tracker #(
    parameter int unsigned FINISH_DIST = 40000,
    parameter int unsigned POS_W       = 16,
    parameter int unsigned TIME_W      = 14,
    parameter int unsigned TIME_MAX    = 9999
) (
    input  logic              clk100Hz,
    input  logic              rst,
    input  logic [6:0]        d_position,
    input  logic              start,
    input  logic              reset_status,
    output logic [POS_W-1:0]  position,
    output logic [TIME_W-1:0] race_time,
    output logic              running,
    output logic              finished,
    output logic              finish_pulse,
`ifdef SPLIT_TIME_EN
    output logic [TIME_W-1:0] split_time,
    output logic              split_valid,
`endif
    output logic              dnf
);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        FINISHED
    } state_t;

    localparam logic [POS_W:0]  FIN_EXT  = (POS_W+1)'(FINISH_DIST);
    localparam logic [POS_W:0]  HALF_EXT = (POS_W+1)'(FINISH_DIST / 2);
    localparam logic [TIME_W:0] TMAX_EXT = (TIME_W+1)'(TIME_MAX);

    state_t            state;
    logic [POS_W:0]    sum;
    logic [TIME_W:0]   t_nxt;

    // One extra bit on both sums so the comparisons never see a wrapped value.
    always_comb begin
        sum   = {1'b0, position} + {{(POS_W-6){1'b0}}, d_position};
        t_nxt = {1'b0, race_time} + (TIME_W+1)'(1);
    end

    assign running  = (state == RUNNING);
    assign finished = (state == FINISHED);

    always_ff @(posedge clk100Hz) begin
        if (rst || reset_status) begin
            state        <= IDLE;
            position     <= '0;
            race_time    <= '0;
            finish_pulse <= 1'b0;
            dnf          <= 1'b0;
`ifdef SPLIT_TIME_EN
            split_time   <= '0;
            split_valid  <= 1'b0;
`endif
        end else begin
            finish_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    position  <= '0;
                    race_time <= '0;
                    dnf       <= 1'b0;
                    if (start) begin
                        state <= RUNNING;
                    end
                end
                RUNNING: begin
`ifdef SPLIT_TIME_EN
                    if (!split_valid && (sum >= HALF_EXT)) begin
                        split_time  <= t_nxt[TIME_W-1:0];
                        split_valid <= 1'b1;
                    end
`endif
                    // Finish is tested first so a simultaneous timeout still counts as a finish.
                    if (sum >= FIN_EXT) begin
                        position     <= POS_W'(FINISH_DIST);
                        race_time    <= t_nxt[TIME_W-1:0];
                        state        <= FINISHED;
                        finish_pulse <= 1'b1;
                        dnf          <= 1'b0;
                    end else if (t_nxt >= TMAX_EXT) begin
                        position     <= sum[POS_W-1:0];
                        race_time    <= TIME_W'(TIME_MAX);
                        state        <= FINISHED;
                        finish_pulse <= 1'b1;
                        dnf          <= 1'b1;
                    end else begin
                        position  <= sum[POS_W-1:0];
                        race_time <= t_nxt[TIME_W-1:0];
                    end
                end
                FINISHED: begin
                    state <= FINISHED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_race_distance_tracker.sv
// Scoreboard bench for race_distance_tracker: a race-level reference model queues expected outputs
// per tick and a monitor compares them against the DUT after each clock edge.
module tb_race_distance_tracker;

    localparam int FIN  = 40000;
    localparam int PW   = 16;
    localparam int TW   = 14;
    localparam int TMAX = 9999;

    logic          clk100Hz = 1'b0;
    logic          rst;
    logic [6:0]    d_position;
    logic          start;
    logic          reset_status;
    logic [PW-1:0] position;
    logic [TW-1:0] race_time;
    logic          running;
    logic          finished;
    logic          finish_pulse;
    logic          dnf;
`ifdef SPLIT_TIME_EN
    logic [TW-1:0] split_time;
    logic          split_valid;
`endif

    always #5 clk100Hz = ~clk100Hz;

    race_distance_tracker #(
        .FINISH_DIST(FIN),
        .POS_W(PW),
        .TIME_W(TW),
        .TIME_MAX(TMAX)
    ) dut (
        .clk100Hz(clk100Hz),
        .rst(rst),
        .d_position(d_position),
        .start(start),
        .reset_status(reset_status),
        .position(position),
        .race_time(race_time),
        .running(running),
        .finished(finished),
        .finish_pulse(finish_pulse),
`ifdef SPLIT_TIME_EN
        .split_time(split_time),
        .split_valid(split_valid),
`endif
        .dnf(dnf)
    );

    typedef struct packed {
        logic [PW-1:0] pos;
        logic [TW-1:0] tm;
        logic          run;
        logic          fin;
        logic          pulse;
        logic          dnf;
        logic [TW-1:0] st;
        logic          sv;
    } snap_t;

    snap_t exp_q[$];
    int vectors    = 0;
    int miscompares = 0;
    int pulse_cnt  = 0;

    // Race-level reference: phase 0 = waiting, 1 = racing, 2 = result held.
    int m_phase, m_pos, m_time, m_pulse, m_dnf, m_st, m_sv;

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_time = 0; m_pulse = 0; m_dnf = 0; m_st = 0; m_sv = 0;
    endtask

    task automatic model_update(input logic r, input logic rs, input logic go, input int d);
        int total, elapsed;
        if (r || rs) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (m_phase == 0) begin
                if (go) m_phase = 1;
            end else if (m_phase == 1) begin
                total   = m_pos + d;
                elapsed = m_time + 1;
                if (m_sv == 0 && total >= FIN / 2) begin
                    m_sv = 1;
                    m_st = elapsed;
                end
                if (total >= FIN) begin
                    m_pos = FIN; m_time = elapsed; m_phase = 2; m_pulse = 1; m_dnf = 0;
                end else if (elapsed >= TMAX) begin
                    m_pos = total; m_time = TMAX; m_phase = 2; m_pulse = 1; m_dnf = 1;
                end else begin
                    m_pos = total; m_time = elapsed;
                end
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.pos   = PW'(m_pos);
        s.tm    = TW'(m_time);
        s.run   = (m_phase == 1);
        s.fin   = (m_phase == 2);
        s.pulse = m_pulse[0];
        s.dnf   = m_dnf[0];
`ifdef SPLIT_TIME_EN
        s.st    = TW'(m_st);
        s.sv    = m_sv[0];
`else
        s.st    = '0;
        s.sv    = 1'b0;
`endif
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.pos   = position;
        s.tm    = race_time;
        s.run   = running;
        s.fin   = finished;
        s.pulse = finish_pulse;
        s.dnf   = dnf;
`ifdef SPLIT_TIME_EN
        s.st    = split_time;
        s.sv    = split_valid;
`else
        s.st    = '0;
        s.sv    = 1'b0;
`endif
        return s;
    endfunction

    task automatic step(input logic r, input logic rs, input logic go, input int d);
        @(negedge clk100Hz);
        rst          = r;
        reset_status = rs;
        start        = go;
        d_position   = 7'(d);
        model_update(r, rs, go, d);
        exp_q.push_back(model_snap());
    endtask

    // Observe the edge whose expectation was just queued, without consuming an extra edge.
    task automatic settle();
        @(posedge clk100Hz);
        #2;
    endtask

    task automatic dchk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    initial begin : monitor
        snap_t e;
        snap_t a;
        forever begin
            @(posedge clk100Hz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_snap();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL tick_outputs t=%0t: got pos=%0d time=%0d run=%b fin=%b pulse=%b dnf=%b st=%0d sv=%b, expected pos=%0d time=%0d run=%b fin=%b pulse=%b dnf=%b st=%0d sv=%b",
                             $time, a.pos, a.tm, a.run, a.fin, a.pulse, a.dnf, a.st, a.sv,
                             e.pos, e.tm, e.run, e.fin, e.pulse, e.dnf, e.st, e.sv);
                end
                if (a.pulse === 1'b1) pulse_cnt++;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; reset_status = 1'b0; start = 1'b0; d_position = '0;
        model_reset();

        // Reset and idle: start low, increments must not accumulate.
        repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 127));
        repeat (5) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 127));
        settle();
        dchk("idle_position", int'(position), 0);
        dchk("idle_running", int'(running), 0);

        // Nominal run at constant 100.
        pulse_cnt = 0;
        step(1'b0, 1'b0, 1'b1, $urandom_range(0, 127));
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0, 1'b0, 100);
        settle();
        dchk("nominal_position", int'(position), 40000);
        dchk("nominal_time", int'(race_time), 400);
        dchk("nominal_dnf", int'(dnf), 0);
        dchk("nominal_finished", int'(finished), 1);
`ifdef SPLIT_TIME_EN
        dchk("nominal_split_time", int'(split_time), 200);
        dchk("nominal_split_valid", int'(split_valid), 1);
`endif
        repeat (5) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 127));
        settle();
        dchk("nominal_pulse_count", pulse_cnt, 1);

        // Overshoot clamp at 127 per tick.
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 315; i++) step(1'b0, 1'b0, 1'b0, 127);
        settle();
        dchk("overshoot_position", int'(position), 40000);
        dchk("overshoot_time", int'(race_time), 315);
        dchk("overshoot_finished", int'(finished), 1);

        // Timeout with zero increments.
        step(1'b0, 1'b1, 1'b0, 0);
        pulse_cnt = 0;
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < TMAX; i++) step(1'b0, 1'b0, 1'b0, 0);
        settle();
        dchk("timeout_time", int'(race_time), 9999);
        dchk("timeout_dnf", int'(dnf), 1);
        dchk("timeout_position", int'(position), 0);
        repeat (3) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 127));
        settle();
        dchk("timeout_pulse_count", pulse_cnt, 1);
        dchk("timeout_finished", int'(finished), 1);

        // Mid-run abort at race_time 150, then restart.
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 60));
        settle();
        dchk("abort_pre_time", int'(race_time), 150);
        step(1'b0, 1'b1, 1'b0, $urandom_range(0, 127));
        settle();
        dchk("abort_position", int'(position), 0);
        dchk("abort_time", int'(race_time), 0);
        dchk("abort_running", int'(running), 0);
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 60));
        settle();
        dchk("restart_time", int'(race_time), 10);

        // Start held high through RUNNING and FINISHED.
        step(1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0, 1'b1, 100);
        repeat (20) step(1'b0, 1'b0, 1'b1, $urandom_range(0, 127));
        settle();
        dchk("held_start_time", int'(race_time), 400);
        dchk("held_start_position", int'(position), 40000);
        dchk("held_start_finished", int'(finished), 1);

        // Randomised races with occasional aborts and a random start level.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) step(1'b1, 1'b0, 1'b0, 0);
            else                           step(1'b0, 1'b1, 1'b0, 0);
            repeat ($urandom_range(0, 4)) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 127));
            step(1'b0, 1'b0, 1'b1, $urandom_range(0, 127));
            for (int i = 0; i < 800; i++)
                step(1'b0, 1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 127));
        end

        settle();
        dchk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/race_distance_tracker.md
Name: race_distance_tracker

Overview:
- Downstream consumer of the per-tick position increment produced by the velocity stage (7-bit `d_position` per 10 ms tick).
- Integrates increments into absolute race distance and times the run in centiseconds.
- Detects the finish line or a timeout, and holds the result for the display and scoring logic.
- Runs one update per `clk100Hz` tick, one three-state race FSM per car instance.

Parameters:
- FINISH_DIST, 40000, distance units to the finish line; must be ≤ 2^POS_W − 1.
- POS_W, 16, width of the position accumulator.
- TIME_W, 14, width of the race timer.
- TIME_MAX, 9999, timer limit in centiseconds (99.99 s); reaching it ends the run as DNF.

Ports:
- clk100Hz  input  1  100 Hz system tick clock.
- rst  input  1  synchronous, active-high reset.
- d_position  input  7  distance increment for this tick, unsigned.
- start  input  1  race start request; a level is accepted, only IDLE reacts.
- reset_status  input  1  synchronous race abort/restart; same effect as rst on all state.
- position  output  POS_W  accumulated distance, registered.
- race_time  output  TIME_W  elapsed centiseconds, registered.
- running  output  1  high while the FSM is in RUNNING.
- finished  output  1  high while the FSM is in FINISHED (either outcome).
- finish_pulse  output  1  one-cycle strobe on entry to FINISHED.
- dnf  output  1  high in FINISHED if the run ended by timeout.

Behaviour:
- Reset and priority:
  - All outputs are 0 in IDLE; the FSM state is IDLE.
  - On rst or reset_status, all outputs and the state return to this reset condition on the next edge.
  - Priority order is rst = reset_status > start > normal update.
- FSM states: IDLE, RUNNING, FINISHED; the state is registered.
- IDLE:
  - position, race_time, dnf, finish_pulse are held at 0.
  - `start` = 1 → next state is RUNNING; position and race_time stay 0 at that edge.
- RUNNING, every edge:
  - Compute a POS_W+1 bit sum, sum = position + d_position (no wrap).
  - Compute t_nxt = race_time + 1.
  - If sum ≥ FINISH_DIST:
    - position ← FINISH_DIST, clamped so the overshoot is discarded.
    - race_time ← t_nxt.
    - state ← FINISHED, finish_pulse ← 1, dnf ← 0.
  - Else, if t_nxt ≥ TIME_MAX:
    - position ← sum, race_time ← TIME_MAX.
    - state ← FINISHED, finish_pulse ← 1, dnf ← 1.
  - Else: position ← sum, race_time ← t_nxt.
  - If finish and timeout occur on the same edge, finish wins (dnf = 0).
  - `start` is ignored while RUNNING.
- FINISHED:
  - position, race_time, dnf hold their values.
  - finish_pulse returns to 0 one cycle after entry.
  - `start` is ignored; only rst or reset_status leave FINISHED (to IDLE).
- Timing:
  - The first increment is added on the edge after the one that enters RUNNING.
  - race_time therefore equals the number of RUNNING-state edges, including the finishing edge.
- Combinational outputs: running and finished are pure decodes of the state register; all other outputs are registered.
- d_position = 0 while RUNNING is legal; the timer still advances.

Optional Feature:
- Macro: SPLIT_TIME_EN.
- When defined:
  - Adds an output `split_time` [TIME_W-1:0] and an output `split_valid` (1 bit).
  - On the first RUNNING edge where sum ≥ FINISH_DIST/2 (integer divide), split_time ← t_nxt and split_valid ← 1.
  - Both then hold until rst or reset_status, which clear them to 0.
  - If the half-way point and the finish occur on the same edge, both are captured with the same t_nxt.
  - On a DNF run where half-way is never reached, split_valid stays 0.
- When not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Nominal run:
  - Stimulus: rst, then start 1 cycle, d_position = 100 constant.
  - Response: position steps by 100; after 400 RUNNING edges position = 40000, race_time = 400, finish_pulse high exactly 1 cycle, dnf = 0.
- Overshoot clamp:
  - Stimulus: d_position = 127.
  - Response: finish on edge 315 (raw sum 40005); position = 40000, race_time = 315.
- Timeout:
  - Stimulus: d_position = 0 after start.
  - Response: race_time reaches 9999, finished = 1, dnf = 1, position = 0, finish_pulse 1 cycle.
- Mid-run abort:
  - Stimulus: reset_status at race_time = 150; then start again.
  - Response: the next edge gives IDLE with all outputs 0; the second run counts from 0.
- Ignored start:
  - Stimulus: hold start = 1 through RUNNING and FINISHED.
  - Response: no restart and no counter reset; values stay frozen in FINISHED.
- SPLIT_TIME_EN (macro defined only):
  - Stimulus: d_position = 100.
  - Response: split_valid rises with split_time = 200 (position 20000); unchanged at finish.
